// File: rtl/pb_debounce_if.sv
// Pushbutton debouncer signal bundle: the raw pin coming in, plus the
// cleaned level and event pulses going out.
interface pb_debounce_if;
  logic PB_raw;
  logic PB_clean;
  logic pressed;
  logic long_press;

  modport master (
    output PB_raw,
    input  PB_clean,
    input  pressed,
    input  long_press
  );

  modport slave (
    input  PB_raw,
    output PB_clean,
    output pressed,
    output long_press
  );
endinterface

// File: rtl/pb_debounce.sv
// Pushbutton debouncer for an active-low button pin.
// The raw pin is synchronised, then a new level is only accepted after
// it has been seen unchanged for DEBOUNCE_CYCLES consecutive samples.
// A one-cycle pulse marks each accepted press, and a second one-cycle
// pulse marks a hold of LONG_CYCLES cycles (at most once per press).
module pb_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned LONG_CYCLES     = 50000000
) (
  input  logic         clk,
  input  logic         rst_n,
  pb_debounce_if.slave bus
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

  // Encoding matches the pin polarity, so the state flop is the clean level.
  typedef enum logic {
    LVL_DOWN = 1'b0,
    LVL_UP   = 1'b1
  } level_t;

  level_t            level;
  logic              sync1;
  logic              sync2;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;
  logic              long_done;
  logic              pressed_q;
  logic              long_q;

  logic clean_now;
  logic differs;
  logic accept;
  logic rise;
  logic long_fire;

  assign clean_now = (level == LVL_UP);
  assign differs   = (sync2 != clean_now);
  assign accept    = differs && (db_cnt == DB_LAST);
  assign rise      = accept && sync2;

  // Two-flop synchroniser; idles at 1 so reset looks like "not pressed".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= bus.PB_raw;
      sync2 <= sync1;
    end
  end

  // Level FSM: count agreeing samples of a differing level, restart on bounce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level     <= LVL_UP;
      db_cnt    <= '0;
      pressed_q <= 1'b0;
    end else begin
      pressed_q <= 1'b0;
      if (!differs) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt    <= '0;
        level     <= sync2 ? LVL_UP : LVL_DOWN;
        pressed_q <= !sync2;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Next hold count: cleared while up or on an accepted release, else saturating.
  always_comb begin
    hold_next = hold_cnt;
    if (clean_now || rise) begin
      hold_next = '0;
    end else if (hold_cnt != HOLD_MAX) begin
      hold_next = hold_cnt + HOLD_W'(1);
    end
  end

  assign long_fire = (hold_next == HOLD_MAX) && !long_done;

  // Hold tracking: fire the long-press pulse once, re-arm when released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      long_done <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      hold_cnt <= hold_next;
      long_q   <= long_fire;
      if (clean_now || rise) begin
        long_done <= 1'b0;
      end else if (long_fire) begin
        long_done <= 1'b1;
      end
    end
  end

  assign bus.PB_clean   = clean_now;
  assign bus.pressed    = pressed_q;
  assign bus.long_press = long_q;

endmodule

// File: tb/tb_pb_debounce.sv
// Testbench for pb_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Stimulus pushes expected output events (level changes and pulses,
// tagged with the clock edge they follow) into a queue; a monitor pops
// and compares every event the DUT actually produces.
module tb_pb_debounce;

  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int LAT  = DB + 2;

  typedef enum int {EV_FALL, EV_RISE, EV_PRESS, EV_LONG} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       edge_at;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   edge_no = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic prev_clean = 1'b1;
  ev_t  exp_q[$];

  pb_debounce_if bus ();

  pb_debounce #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LONG)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_no <= edge_no + 1;

  task automatic expectEvent(input ev_kind_t kind, input int at);
    ev_t e;
    e.kind    = kind;
    e.edge_at = at;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t kind);
    ev_t e;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL unexpected_event: got %s after edge %0d, expected no event",
               kind.name(), edge_no);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.edge_at != edge_no) begin
        tests_failed++;
        $display("[TB] FAIL event_order: got %s after edge %0d, expected %s after edge %0d",
                 kind.name(), edge_no, e.kind.name(), e.edge_at);
      end
    end
  endtask

  // Monitor: every level change and pulse is an event to be matched.
  always @(negedge clk) begin
    if (bus.PB_clean !== prev_clean) observe(bus.PB_clean === 1'b1 ? EV_RISE : EV_FALL);
    if (bus.pressed === 1'b1) observe(EV_PRESS);
    if (bus.long_press === 1'b1) observe(EV_LONG);
    prev_clean = bus.PB_clean;
  end

  task automatic checkOutput(input string name, input logic exp_clean,
                             input logic exp_pressed, input logic exp_long);
    tests_run += 3;
    if (bus.PB_clean !== exp_clean) begin
      tests_failed++;
      $display("[TB] FAIL %s.PB_clean: got %b, expected %b", name, bus.PB_clean, exp_clean);
    end
    if (bus.pressed !== exp_pressed) begin
      tests_failed++;
      $display("[TB] FAIL %s.pressed: got %b, expected %b", name, bus.pressed, exp_pressed);
    end
    if (bus.long_press !== exp_long) begin
      tests_failed++;
      $display("[TB] FAIL %s.long_press: got %b, expected %b", name, bus.long_press, exp_long);
    end
  endtask

  // Drives the raw pin immediately (caller sits on a negedge) and reports the edge count.
  task automatic applyStimulus(input logic value, output int base);
    bus.PB_raw = value;
    base = edge_no;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int rel;

    // Test 1: reset held with the pin low.
    rst_n = 1'b0;
    bus.PB_raw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset", 1'b1, 1'b0, 1'b0);
    end
    bus.PB_raw = 1'b1;
    waitCycles(1);
    rst_n = 1'b1;
    waitCycles(5);
    checkOutput("idle", 1'b1, 1'b0, 1'b0);

    // Tests 2 and 4: clean press held 40 cycles past the fall, single long press.
    applyStimulus(1'b0, base);
    expectEvent(EV_FALL, base + LAT);
    expectEvent(EV_PRESS, base + LAT);
    expectEvent(EV_LONG, base + LAT + LONG);
    waitCycles(LAT - 1);
    checkOutput("before_fall", 1'b1, 1'b0, 1'b0);
    waitCycles(1 + 40);
    checkOutput("long_hold", 1'b0, 1'b0, 1'b0);

    // Test 5: release, then a fresh press held past the long threshold.
    applyStimulus(1'b1, base);
    expectEvent(EV_RISE, base + LAT);
    waitCycles(10);
    checkOutput("released", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, base);
    expectEvent(EV_FALL, base + LAT);
    expectEvent(EV_PRESS, base + LAT);
    expectEvent(EV_LONG, base + LAT + LONG);
    waitCycles(30);
    applyStimulus(1'b1, base);
    expectEvent(EV_RISE, base + LAT);
    waitCycles(10);

    // Release accepted on the very edge the hold would reach its limit.
    applyStimulus(1'b0, base);
    expectEvent(EV_FALL, base + LAT);
    expectEvent(EV_PRESS, base + LAT);
    waitCycles(LONG);
    applyStimulus(1'b1, rel);
    expectEvent(EV_RISE, rel + LAT);
    waitCycles(12);
    checkOutput("boundary_release", 1'b1, 1'b0, 1'b0);

    // Test 3: bounce shorter than the debounce window never registers.
    applyStimulus(1'b0, base);
    waitCycles(3);
    applyStimulus(1'b1, base);
    waitCycles(1);
    applyStimulus(1'b0, base);
    waitCycles(3);
    applyStimulus(1'b1, base);
    waitCycles(10);
    checkOutput("bounce", 1'b1, 1'b0, 1'b0);

    // Test 6: reset lands with the debounce count at 2; count restarts from zero.
    applyStimulus(1'b0, base);
    waitCycles(4);
    rst_n = 1'b0;
    waitCycles(1);
    checkOutput("mid_reset", 1'b1, 1'b0, 1'b0);
    waitCycles(2);
    rst_n = 1'b1;
    base = edge_no;
    expectEvent(EV_FALL, base + LAT);
    expectEvent(EV_PRESS, base + LAT);
    expectEvent(EV_LONG, base + LAT + LONG);
    waitCycles(LAT - 1);
    checkOutput("after_reset_wait", 1'b1, 1'b0, 1'b0);
    waitCycles(25);
    applyStimulus(1'b1, base);
    expectEvent(EV_RISE, base + LAT);
    waitCycles(12);
    checkOutput("final", 1'b1, 1'b0, 1'b0);

    // Any expectation never matched is a missing event.
    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL missing_event: got nothing, expected %s after edge %0d",
               e.kind.name(), e.edge_at);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
